// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int          ILEN         = 32;

  // One instruction queue slot: fetched word, its byte PC, fetch-error flag.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [31:0]     pc;
    logic            adel;
  } ifu_entry_t;

  // Word-aligned and inside [base, base+span). The offset subtraction keeps
  // the compare correct even if the window sits near the top of memory.
  function automatic logic in_window(input logic [31:0] a,
                                     input logic [31:0] base,
                                     input logic [32:0] span);
    logic [31:0] off;
    off = a - base;
    return (a[1:0] == 2'b00) && ({1'b0, off} < span);
  endfunction

endpackage

// File: rtl/ifu_queue.sv
// Circular instruction FIFO with push, pop and single-cycle flush.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     flush,
  input  logic                     push,
  input  ifu_entry_t               wdata,
  input  logic                     pop,
  output ifu_entry_t               head,
  output logic                     valid,
  output logic [$clog2(QDEPTH):0]  count
);

  localparam int             AW   = $clog2(QDEPTH);
  localparam logic [AW:0]    FULL = (AW+1)'(QDEPTH);

  ifu_entry_t    mem [QDEPTH];
  logic [AW-1:0] rptr, wptr;
  logic          do_push, do_pop;

  // A pop frees the head slot at the same edge, so a full queue still
  // accepts a push when it is also being drained.
  assign valid   = (count != '0);
  assign do_pop  = pop & valid & ~flush;
  assign do_push = push & ~flush & ((count != FULL) | do_pop);
  assign head    = mem[rptr];

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Entry storage, no reset needed: count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch PC generation, memory credit/discard tracking and instruction queue.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          IMEM_WORDS = 4096,
  parameter int          QDEPTH     = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic        branch,
  input  logic        intreq,
  input  logic [31:0] npcout,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc8,
  output logic        adel
);

  localparam int          CW    = $clog2(QDEPTH) + 1;
  localparam logic [32:0] SPAN  = 33'(IMEM_WORDS) << 2;
  localparam logic [CW:0] DEPTH = (CW+1)'(QDEPTH);

  logic [31:0]   fpc, rsp_pc;
  logic          halt;
  logic [CW-1:0] out_cnt, disc_cnt, occ, disc_left;
  logic [CW:0]   pend, left;
  logic          legal, grant, redir, retire, drop, err_push;
  logic          q_push, q_pop, q_flush, q_valid;
  ifu_entry_t    q_wdata, q_head;

  assign legal     = in_window(fpc, RESET_PC, SPAN);
  assign redir     = intreq | branch;
  // Credit: every queued entry plus every live request reserves a slot, so
  // a returning response can always be pushed.
  assign imem_req  = !halt && !clr && legal &&
                     (({1'b0, occ} + {1'b0, out_cnt}) < DEPTH);
  assign imem_addr = fpc;
  assign grant     = imem_req & imem_gnt;

  // Responses to abandoned requests come back first (in order) and are eaten.
  assign drop      = imem_rvalid & (disc_cnt != '0);
  assign retire    = imem_rvalid & (disc_cnt == '0);
  // A bad fetch PC becomes a queue entry only after live traffic drains,
  // keeping it behind the instructions fetched before it.
  assign err_push  = !legal && !halt && (out_cnt == '0) && ({1'b0, occ} < DEPTH);

  assign q_flush   = clr | redir;
  assign q_push    = !q_flush && (retire || err_push);
  assign q_pop     = q_valid && !stall && !q_flush;
  assign q_wdata   = retire ? ifu_entry_t'{instr: imem_rdata, pc: rsp_pc, adel: 1'b0}
                            : ifu_entry_t'{instr: '0,         pc: fpc,    adel: 1'b1};

  // Everything still in flight after this cycle, for reset/redirect to discard.
  always_comb begin
    pend = {1'b0, out_cnt} + {1'b0, disc_cnt} + (CW+1)'(grant);
    left = (imem_rvalid && pend != '0) ? pend - (CW+1)'(1) : pend;
  end
  assign disc_left = left[CW] ? '1 : left[CW-1:0];

  // Fetch PC, response PC, halt and the two traffic counters.
  always_ff @(posedge clk) begin
    if (clr) begin
      fpc      <= RESET_PC;
      rsp_pc   <= RESET_PC;
      halt     <= 1'b0;
      out_cnt  <= '0;
      disc_cnt <= disc_left;
    end else if (redir) begin
      fpc      <= npcout;
      rsp_pc   <= npcout;
      halt     <= 1'b0;
      out_cnt  <= '0;
      disc_cnt <= disc_left;
    end else begin
      if (grant)    fpc    <= fpc + 32'd4;
      if (retire)   rsp_pc <= rsp_pc + 32'd4;
      if (err_push) halt   <= 1'b1;
      case ({grant, retire && (out_cnt != '0)})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: ;
      endcase
      if (drop) disc_cnt <= disc_cnt - CW'(1);
    end
  end

  ifu_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .flush (q_flush),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .head  (q_head),
    .valid (q_valid),
    .count (occ)
  );

  // Head presentation is masked during reset so stale entries never leak.
  assign instr_valid = q_valid & ~clr;
  assign instr       = instr_valid ? q_head.instr : 32'd0;
  assign pc8         = instr_valid ? q_head.pc + 32'd8 : RESET_PC + 32'd8;
  assign adel        = instr_valid & q_head.adel;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed and random checks of ifu_fetch_queue against an epoch-tagged model.
module tb_ifu_fetch_queue;
  import ifu_pkg::*;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        clr, stall, branch, intreq, imem_gnt, imem_rvalid;
  logic        imem_req, instr_valid, adel;
  logic [31:0] npcout, imem_addr, imem_rdata, instr, pc8;

  ifu_fetch_queue dut (
    .clk(clk), .clr(clr), .stall(stall), .branch(branch), .intreq(intreq),
    .npcout(npcout), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc8(pc8), .adel(adel)
  );

  always #5 clk = ~clk;

  // Memory-side view: each accepted request remembers its address, the
  // redirect epoch it was issued in, and the cycle its response returns.
  typedef struct { logic [31:0] addr; int ep; int due; } mreq_t;
  mreq_t      mem[$];
  ifu_entry_t mq[$];
  logic [31:0] m_fpc;
  logic        m_halt;
  int          m_ep, cnum, last_due, lat_lo, lat_hi;
  int          n_chk, n_pass, n_grants;
  logic        s_valid, s_req, s_adel;
  logic [31:0] s_pc8, s_addr, s_instr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a < 32'h7000);
  endfunction

  function automatic int live();
    int n = 0;
    foreach (mem[j]) if (mem[j].ep == m_ep) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock cycle: drive, compare against model, advance the model.
  task automatic cyc(input logic c, input logic s, input logic b, input logic i,
                     input logic [31:0] n, input logic g);
    logic        rv, e_req, e_valid, e_adel, grant;
    logic [31:0] e_instr, e_pc8;
    int          live0, occ0, d;
    mreq_t       rsp;
    clr = c; stall = s; branch = b; intreq = i; npcout = n; imem_gnt = g;
    rv = (mem.size() > 0) && (mem[0].due == cnum);
    imem_rvalid = rv;
    imem_rdata  = rv ? mdata(mem[0].addr) : $urandom();
    #2;
    live0   = live();
    occ0    = mq.size();
    e_req   = !c && !m_halt && (occ0 + live0) < QD && legal(m_fpc);
    e_valid = !c && occ0 > 0;
    e_instr = e_valid ? mq[0].instr : 32'd0;
    e_pc8   = e_valid ? mq[0].pc + 32'd8 : 32'h3008;
    e_adel  = e_valid && mq[0].adel;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_instr = instr; s_pc8 = pc8; s_adel = adel;
    chk("imem_req", 32'(s_req), 32'(e_req));
    chk("imem_addr", s_addr, m_fpc);
    chk("instr_valid", 32'(s_valid), 32'(e_valid));
    chk("instr", s_instr, e_instr);
    chk("pc8", s_pc8, e_pc8);
    chk("adel", 32'(s_adel), 32'(e_adel));
    if (rv) rsp = mem.pop_front();
    grant = e_req && g;
    if (grant) begin
      n_grants++;
      d = cnum + int'($urandom_range(lat_hi, lat_lo));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem.push_back(mreq_t'{addr: m_fpc, ep: m_ep, due: d});
    end
    if (c) begin
      mq.delete(); m_fpc = 32'h3000; m_halt = 1'b0; m_ep++;
    end else if (b || i) begin
      mq.delete(); m_fpc = n; m_halt = 1'b0; m_ep++;
    end else begin
      if (occ0 > 0 && !s) void'(mq.pop_front());
      if (rv && rsp.ep == m_ep)
        mq.push_back(ifu_entry_t'{instr: mdata(rsp.addr), pc: rsp.addr, adel: 1'b0});
      if (!legal(m_fpc) && !m_halt && live0 == 0 && occ0 < QD) begin
        mq.push_back(ifu_entry_t'{instr: 32'd0, pc: m_fpc, adel: 1'b1});
        m_halt = 1'b1;
      end
      if (grant) m_fpc = m_fpc + 32'd4;
    end
    @(posedge clk); #1;
    cnum++;
  endtask

  // Idle cycles until the head is valid, bounded.
  task automatic wait_valid(input string tag);
    int k = 0;
    do cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1); while (!s_valid && ++k < 20);
    chk(tag, 32'(s_valid), 32'd1);
  endtask

  initial begin
    logic        c, s, b, i, g;
    logic [31:0] npc;
    int          r, sel;
    n_chk = 0; n_pass = 0; n_grants = 0; cnum = 0; last_due = -1;
    m_fpc = 32'h3000; m_halt = 1'b0; m_ep = 0; lat_lo = 1; lat_hi = 1;
    clr = 1'b1; stall = 1'b0; branch = 1'b0; intreq = 1'b0; npcout = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk); #1;

    // Straight-line fetch, 1-cycle memory.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("A_clr_req", 32'(s_req), 32'd0);
    chk("A_clr_pc8", s_pc8, 32'h3008);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("A_valid", 32'(s_valid), (k >= 3) ? 32'd1 : 32'd0);
      if (k >= 3) chk("A_pc8", s_pc8, 32'h3008 + 32'(4 * (k - 3)));
    end

    // Decode stalled: credit limit caps fetch at the queue depth.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    n_grants = 0;
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("B_grants", 32'(n_grants), 32'd4);
    chk("B_req_idle", 32'(s_req), 32'd0);
    chk("B_head", s_pc8, 32'h3008);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("B_drain", s_pc8, 32'h3008 + 32'(4 * k));
    end

    // Branch with three requests in flight at latency 3.
    lat_lo = 3; lat_hi = 3;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h3100, 1'b1);
    chk("C_req_at_br", 32'(s_req), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("C_tgt", s_addr, 32'h3100);
    chk("C_tgt_req", 32'(s_req), 32'd1);
    wait_valid("C_seen");
    chk("C_pc8", s_pc8, 32'h3108);
    chk("C_instr", s_instr, mdata(32'h3100));

    // Misaligned target faults, fetch halts until an interrupt.
    lat_lo = 1; lat_hi = 1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h3002, 1'b1);
    wait_valid("D_seen");
    chk("D_adel", 32'(s_adel), 32'd1);
    chk("D_instr", s_instr, 32'd0);
    chk("D_pc8", s_pc8, 32'h300A);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("D_halted", 32'(s_req), 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h4180, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("D_irq_req", 32'(s_req), 32'd1);
    chk("D_irq_addr", s_addr, 32'h4180);

    // Last legal word, then the first word past the window.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h6FFC, 1'b1);
    wait_valid("D_last_seen");
    chk("D_last_pc8", s_pc8, 32'h7004);
    chk("D_last_adel", 32'(s_adel), 32'd0);
    wait_valid("D_past_seen");
    chk("D_past_pc8", s_pc8, 32'h7008);
    chk("D_past_adel", 32'(s_adel), 32'd1);

    // Simultaneous redirects, and reset overriding an interrupt.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h5100, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h5200, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("E_tgt", s_addr, 32'h5200);
    lat_lo = 3; lat_hi = 3;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h6000, 1'b1);
    chk("E_clr_valid", 32'(s_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("E_clr_addr", s_addr, 32'h3000);
    chk("E_after_valid", 32'(s_valid), 32'd0);
    wait_valid("E_seen");
    chk("E_pc8", s_pc8, 32'h3008);
    chk("E_instr", s_instr, mdata(32'h3000));

    // Random traffic.
    lat_lo = 1; lat_hi = 3;
    for (int k = 0; k < 800; k++) begin
      r   = int'($urandom_range(99, 0));
      c   = (r < 2);
      b   = ($urandom_range(99, 0) < 5);
      i   = ($urandom_range(99, 0) < 3);
      s   = ($urandom_range(99, 0) < 30);
      g   = ($urandom_range(99, 0) < 70);
      sel = int'($urandom_range(9, 0));
      case (sel)
        7:       npc = 32'h3000 + 32'(4 * $urandom_range(4095, 0)) + 32'(1 + $urandom_range(2, 0));
        8:       npc = 32'h7000 + 32'(4 * $urandom_range(3, 0));
        9:       npc = 32'h2FFC;
        default: npc = 32'h3000 + 32'(4 * $urandom_range(4095, 0));
      endcase
      cyc(c, s, b, i, npc, g);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
